vcsr_rmw: RTL

Virtual-CSR field access sequencer sitting directly downstream of the VCSR configuration table. When the core executes a CSR instruction that hits a VCSR alias, this block takes the resolved target (address, bit offset, field width) and performs a three-cycle read-modify-write on the target CSR. It returns the old field value, right-aligned and zero-extended, for rd, and stalls the pipeline while busy.

---
 rtl/vcsr_rmw.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vcsr_rmw.sv
// ---------------------------------------------------------------------------------------------
// vcsr_rmw: virtual-CSR field read-modify-write sequencer.
//
// Takes a resolved VCSR alias target (CSR address, field LSB, field width-1) and performs a
// three-cycle read-modify-write of that field on the target CSR. The old field value is
// returned right-aligned and zero-extended for rd. The pipeline is stalled while busy.
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   start_i      valid VCSR access this cycle (sampled only when idle)
//   csr_op_i     CSR operation (funct3 encoding)
//   rs1_data_i   register operand
//   rs1_zimm_i   rs1 index, or zimm for immediate ops
//   in_addr_i    target CSR address
//   in_offset_i  field LSB position
//   in_width_i   field width minus one
//   rd_addr_o    target CSR read address (non-zero only in READ)
//   rd_data_i    target CSR value, combinational read
//   wr_en_o      one-cycle write strobe
//   wr_addr_o    write address (non-zero only in WRITE)
//   wr_data_o    full merged word (non-zero only in WRITE)
//   result_o     old field value, held until the next completion
//   done_o       one-cycle completion pulse
//   stall_o      pipeline hold request
// ---------------------------------------------------------------------------------------------

package config_pkg;

    typedef logic [11:0] CsrAddrT;

    // funct3 encoding: bit 2 selects the immediate form, bits [1:0] select W/S/C.
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    parameter CsrAddrT     VcsrBase   = 12'h7C0;
    parameter int unsigned VcsrAmount = 8;

endpackage

module vcsr_rmw #(
    parameter config_pkg::CsrAddrT VcsrBase   = config_pkg::VcsrBase,
    parameter int unsigned         VcsrAmount = config_pkg::VcsrAmount
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  config_pkg::csr_op_t  csr_op_i,
    input  logic [31:0]          rs1_data_i,
    input  logic [4:0]           rs1_zimm_i,
    input  config_pkg::CsrAddrT  in_addr_i,
    input  logic [4:0]           in_offset_i,
    input  logic [4:0]           in_width_i,
    output config_pkg::CsrAddrT  rd_addr_o,
    input  logic [31:0]          rd_data_i,
    output logic                 wr_en_o,
    output config_pkg::CsrAddrT  wr_addr_o,
    output logic [31:0]          wr_data_o,
    output logic [31:0]          result_o,
    output logic                 done_o,
    output logic                 stall_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_e;

    localparam logic [31:0] ProtLo = 32'(VcsrBase);
    localparam logic [31:0] ProtHi = 32'(VcsrBase) + 32'(2 * VcsrAmount);

    state_e              state_q, state_d;
    logic [1:0]          kind_q, kind_d;       // op[1:0]: 01 = W, 10 = S, 11 = C
    config_pkg::CsrAddrT addr_q, addr_d;
    logic [4:0]          offset_q, offset_d;
    logic [4:0]          width_q, width_d;
    logic [31:0]         operand_q, operand_d;
    logic                nowrite_q, nowrite_d;
    logic [31:0]         old_q, old_d;
    logic [31:0]         new_q, new_d;
    logic [31:0]         result_q, result_d;

    // Field arithmetic on the latched request and the live CSR read data.
    logic [31:0] ones;
    logic [31:0] mask;
    logic [31:0] old_field;
    logic [31:0] new_field;
    logic [31:0] merged;
    logic        in_prot;

    assign in_prot = ({20'd0, in_addr_i} >= ProtLo) && ({20'd0, in_addr_i} < ProtHi);

    always_comb begin
        // A 32-bit-wide field would need 1 << 32; handle it as all ones instead.
        if (width_q == 5'd31) begin
            ones = '1;
        end else begin
            ones = (32'd1 << ({1'b0, width_q} + 6'd1)) - 32'd1;
        end
        // Field bits that fall above bit 31 are simply shifted out.
        mask      = ones << offset_q;
        old_field = (rd_data_i & mask) >> offset_q;
        unique case (kind_q)
            2'b10:   new_field = old_field | operand_q;
            2'b11:   new_field = old_field & ~operand_q;
            default: new_field = operand_q;
        endcase
        merged = (rd_data_i & ~mask) | ((new_field << offset_q) & mask);
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        addr_d    = addr_q;
        offset_d  = offset_q;
        width_d   = width_q;
        operand_d = operand_q;
        nowrite_d = nowrite_q;
        old_d     = old_q;
        new_d     = new_q;
        result_d  = result_q;

        rd_addr_o = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        done_o    = 1'b0;
        stall_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    // Gated so that every output reads 0 while reset is held.
                    stall_o   = !reset_i;
                    kind_d    = csr_op_i[1:0];
                    addr_d    = in_addr_i;
                    offset_d  = in_offset_i;
                    width_d   = in_width_i;
                    operand_d = csr_op_i[2] ? {27'd0, rs1_zimm_i} : rs1_data_i;
                    // S/C with a zero source never writes; protected range never writes.
                    nowrite_d = (csr_op_i[1] && (rs1_zimm_i == 5'd0)) || in_prot;
                    state_d   = StRead;
                end
            end
            StRead: begin
                rd_addr_o = addr_q;
                stall_o   = 1'b1;
                old_d     = old_field;
                new_d     = merged;
                state_d   = StWrite;
            end
            StWrite: begin
                wr_en_o   = !nowrite_q;
                wr_addr_o = addr_q;
                wr_data_o = new_q;
                done_o    = 1'b1;
                result_d  = old_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            kind_q    <= 2'b00;
            addr_q    <= '0;
            offset_q  <= '0;
            width_q   <= '0;
            operand_q <= '0;
            nowrite_q <= 1'b0;
            old_q     <= '0;
            new_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            addr_q    <= addr_d;
            offset_q  <= offset_d;
            width_q   <= width_d;
            operand_q <= operand_d;
            nowrite_q <= nowrite_d;
            old_q     <= old_d;
            new_q     <= new_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;

endmodule
